// File: rtl/wn_pdcchrx_freq_chest_expand.sv
// rtl/wn_pdcchrx_freq_chest_expand.sv - repeats each averaged DMRS channel estimate over its data REs
// Optional macro WN_PDCCHRX_CHEST_EXPAND_REIDX_EN adds data_out_tuser (RE index within symbol).
module wn_pdcchrx_freq_chest_expand #(
    parameter int nRx = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [4:0]        config_in_tdata,
    input  logic              config_in_tvalid,
    output logic              config_in_tready,
    input  logic [nRx*32-1:0] data_in_tdata,
    input  logic              data_in_tvalid,
    output logic              data_in_tready,
    input  logic              data_in_tlast,
    output logic [nRx*32-1:0] data_out_tdata,
    output logic              data_out_tvalid,
    input  logic              data_out_tready,
    output logic              data_out_tlast
`ifdef WN_PDCCHRX_CHEST_EXPAND_REIDX_EN
    ,
    output logic [10:0]       data_out_tuser
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    state_t     state, state_nxt;
    logic [4:0] rep_cnt, rep_max;
    logic [1:0] sym_cnt, sym_max;
    logic       held_last;
    logic       out_hs, in_hs, last_beat;

    assign out_hs    = data_out_tvalid && data_out_tready;
    assign in_hs     = data_in_tvalid && data_in_tready;
    assign last_beat = (state == EXPAND) && out_hs && (rep_cnt == rep_max);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Ready signals are pure state decodes; rstn gating keeps config_in_tready low during reset.
    always_comb begin
        state_nxt        = state;
        config_in_tready = 1'b0;
        data_in_tready   = 1'b0;
        case (state)
            IDLE: begin
                config_in_tready = rstn;
                if (config_in_tvalid) state_nxt = LOAD;
            end
            LOAD: begin
                data_in_tready = 1'b1;
                if (data_in_tvalid) state_nxt = EXPAND;
            end
            EXPAND: begin
                if (last_beat) begin
                    if (held_last) begin
                        state_nxt = (sym_cnt == sym_max) ? IDLE : LOAD;
                    end else begin
                        data_in_tready = 1'b1;
                        state_nxt      = data_in_tvalid ? EXPAND : LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt         <= '0;
            rep_max         <= '0;
            sym_cnt         <= '0;
            sym_max         <= '0;
            held_last       <= 1'b0;
            data_out_tdata  <= '0;
            data_out_tvalid <= 1'b0;
            data_out_tlast  <= 1'b0;
        end else begin
            if (state == IDLE && config_in_tvalid) begin
                case (config_in_tdata[2:0])
                    3'd2:    rep_max <= 5'd5;
                    3'd3:    rep_max <= 5'd8;
                    default: rep_max <= 5'd17;
                endcase
                sym_max <= (config_in_tdata[4:3] == 2'd0) ? 2'd0 : config_in_tdata[4:3] - 2'd1;
                sym_cnt <= '0;
            end
            if (in_hs) begin
                data_out_tdata  <= data_in_tdata;
                held_last       <= data_in_tlast;
                rep_cnt         <= '0;
                data_out_tvalid <= 1'b1;
                data_out_tlast  <= 1'b0;
            end else if (last_beat) begin
                data_out_tvalid <= 1'b0;
                data_out_tlast  <= 1'b0;
                rep_cnt         <= '0;
                if (held_last) sym_cnt <= (sym_cnt == sym_max) ? 2'd0 : sym_cnt + 2'd1;
            end else if (state == EXPAND && out_hs) begin
                rep_cnt        <= rep_cnt + 5'd1;
                data_out_tlast <= held_last && ((rep_cnt + 5'd1) == rep_max);
            end
        end
    end

`ifdef WN_PDCCHRX_CHEST_EXPAND_REIDX_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       data_out_tuser <= '0;
        else if (out_hs) data_out_tuser <= data_out_tlast ? 11'd0 : data_out_tuser + 11'd1;
    end
`endif

endmodule

// File: tb/tb_wn_pdcchrx_freq_chest_expand.sv
// tb/tb_wn_pdcchrx_freq_chest_expand.sv - randomized self-checking bench for the chest expander
module tb_wn_pdcchrx_freq_chest_expand;

    localparam int NRX = 2;
    localparam int W   = NRX * 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [4:0]   config_in_tdata = '0;
    logic         config_in_tvalid = 1'b0;
    logic         config_in_tready;
    logic [W-1:0] data_in_tdata = '0;
    logic         data_in_tvalid = 1'b0;
    logic         data_in_tready;
    logic         data_in_tlast = 1'b0;
    logic [W-1:0] data_out_tdata;
    logic         data_out_tvalid;
    logic         data_out_tready = 1'b0;
    logic         data_out_tlast;
`ifdef WN_PDCCHRX_CHEST_EXPAND_REIDX_EN
    logic [10:0]  data_out_tuser;
`endif

    always #5 clk = ~clk;

    wn_pdcchrx_freq_chest_expand #(.nRx(NRX)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .config_in_tdata  (config_in_tdata),
        .config_in_tvalid (config_in_tvalid),
        .config_in_tready (config_in_tready),
        .data_in_tdata    (data_in_tdata),
        .data_in_tvalid   (data_in_tvalid),
        .data_in_tready   (data_in_tready),
        .data_in_tlast    (data_in_tlast),
        .data_out_tdata   (data_out_tdata),
        .data_out_tvalid  (data_out_tvalid),
        .data_out_tready  (data_out_tready),
`ifdef WN_PDCCHRX_CHEST_EXPAND_REIDX_EN
        .data_out_tuser   (data_out_tuser),
`endif
        .data_out_tlast   (data_out_tlast)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        int           idx;
    } beat_t;

    beat_t expq[$];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s differs", tag);
        end
    endtask

    function automatic int reps_for(input logic [2:0] f);
        if (f == 3'd2) return 6;
        if (f == 3'd3) return 9;
        return 18;
    endfunction

    // Builds S symbols of nest random estimates, expands them in the model, then drives and scores.
    task automatic run(input logic [4:0] cfg, input int nest, input int rmode,
                       input bit cont, input bit noise, input bit gapless);
        logic [W-1:0] ests[$];
        bit           lasts[$];
        logic [W-1:0] e, prev_d;
        logic         prev_l;
        beat_t        b;
        int r, s, ri, cyc, ii, first, lastc, nb;
        bit pend, lat, prev_stall;
        r = reps_for(cfg[2:0]);
        s = (cfg[4:3] == 2'd0) ? 1 : int'(cfg[4:3]);
        for (int si = 0; si < s; si++)
            for (int ei = 0; ei < nest; ei++) begin
                for (int w = 0; w < NRX; w++) e[w*32 +: 32] = $urandom;
                ests.push_back(e);
                lasts.push_back(ei == nest - 1);
            end
        ri = 0;
        foreach (ests[i])
            for (int k = 0; k < r; k++) begin
                b.d = ests[i];
                b.l = lasts[i] && (k == r - 1);
                b.idx = ri;
                expq.push_back(b);
                ri = b.l ? 0 : ri + 1;
            end

        @(negedge clk);
        config_in_tvalid = 1'b1;
        config_in_tdata  = cfg;
        #1 check("cfg_ready_idle", config_in_tready, 1);

        cyc = 0; ii = 0; pend = 0; lat = 0; prev_stall = 0;
        first = -1; lastc = -1; nb = 0; prev_d = '0; prev_l = 0;
        while (expq.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (lat) check("latency", data_out_tvalid, 1);
            lat = 0;
            if (ii < ests.size()) begin
                if (!pend) pend = cont || ($urandom % 3 != 0);
                data_in_tvalid = pend;
                data_in_tdata  = ests[ii];
                data_in_tlast  = lasts[ii];
            end else data_in_tvalid = 1'b0;
            data_out_tready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(cyc % 2) : 1'($urandom % 2);
            config_in_tvalid = noise;
            config_in_tdata  = 5'($urandom);
            #1;
            if (noise) check("cfg_ignored", config_in_tready, 0);
            if (data_in_tvalid && data_in_tready) begin
                ii++;
                pend = 0;
                lat  = 1;
            end
            if (data_out_tvalid) begin
                if (prev_stall) begin
                    check("stall_tdata", data_out_tdata, prev_d);
                    check("stall_tlast", data_out_tlast, prev_l);
                end
                if (data_out_tready) begin
                    b = expq.pop_front();
                    check("tdata", data_out_tdata, b.d);
                    check("tlast", data_out_tlast, b.l);
`ifdef WN_PDCCHRX_CHEST_EXPAND_REIDX_EN
                    check("tuser", data_out_tuser, b.idx);
`endif
                    nb++;
                    if (first < 0) first = cyc;
                    lastc = cyc;
                end
                prev_stall = !data_out_tready;
                prev_d = data_out_tdata;
                prev_l = data_out_tlast;
            end else prev_stall = 0;
        end
        check("timeout_left", expq.size(), 0);
        expq.delete();
        check("inputs_taken", ii, ests.size());
        if (gapless) check("gapless", lastc - first + 1, nb);
        @(negedge clk);
        config_in_tvalid = 1'b0;
        data_in_tvalid   = 1'b0;
        #1;
        check("end_tvalid", data_out_tvalid, 0);
        check("end_cfg_ready", config_in_tready, 1);
        check("end_in_ready", data_in_tready, 0);
    endtask

    initial begin
        int beats, guard;
        #1;
        check("rst_tvalid", data_out_tvalid, 0);
        check("rst_tlast", data_out_tlast, 0);
        check("rst_tdata", data_out_tdata, 0);
        check("rst_in_ready", data_in_tready, 0);
        check("rst_cfg_ready", config_in_tready, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("rel_cfg_ready", config_in_tready, 1);

        run(5'b01_010, 2, 0, 1, 0, 1);
        run(5'b01_011, 4, 0, 1, 0, 1);
        run(5'b01_110, 2, 1, 1, 0, 0);
        run(5'b10_010, 2, 2, 0, 1, 0);
        run(5'b00_111, 1, 2, 0, 0, 0);
        run(5'b11_000, 2, 0, 0, 1, 0);

        // Reset in the middle of an expansion, then a fresh single-estimate run.
        @(negedge clk);
        config_in_tvalid = 1'b1;
        config_in_tdata  = 5'b01_010;
        @(negedge clk);
        config_in_tvalid = 1'b0;
        data_in_tvalid   = 1'b1;
        data_in_tdata    = 64'h0123_4567_89ab_cdef;
        data_in_tlast    = 1'b1;
        data_out_tready  = 1'b1;
        beats = 0;
        guard = 0;
        while (beats < 4 && guard < 50) begin
            #1;
            if (data_out_tvalid) beats++;
            @(negedge clk);
            if (data_out_tvalid) data_in_tvalid = 1'b0;
            guard++;
        end
        check("pre_reset_beats", beats, 4);
        rstn = 1'b0;
        #1;
        check("mid_rst_tvalid", data_out_tvalid, 0);
        check("mid_rst_tdata", data_out_tdata, 0);
        check("mid_rst_in_ready", data_in_tready, 0);
        check("mid_rst_cfg_ready", config_in_tready, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_cfg_ready", config_in_tready, 1);
        check("post_rst_tvalid", data_out_tvalid, 0);
        run(5'b01_010, 1, 0, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wn_pdcchrx_freq_chest_expand.md
WN_PDCCHRX_FREQ_CHEST_EXPAND -- requirements
Module: wn_pdcchrx_freq_chest_expand

Interface
REQ-001 SHALL have parameter: nRx, default 2, number of receive antennas (each antenna one Q2.14 complex sample, 16b real low / 16b imag high).
REQ-002 SHALL have ports: clk  in  1  system clock; rstn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: config_in_tdata  in  5  [2:0] tone average factor, [4:3] number of symbols; config_in_tvalid  in  1; config_in_tready  out  1.
REQ-004 SHALL have ports: data_in_tdata  in  nRx*32  averaged channel estimate from tone averager; data_in_tvalid  in  1; data_in_tready  out  1; data_in_tlast  in  1  last estimate of symbol.
REQ-005 SHALL have ports: data_out_tdata  out  nRx*32  per-data-RE channel estimate to equalizer; data_out_tvalid  out  1; data_out_tready  in  1; data_out_tlast  out  1  last RE of symbol.

Function
REQ-006 SHALL implement states IDLE, LOAD, EXPAND; reset state IDLE.
REQ-007 IDLE: config_in_tready=1; on config_in_tvalid capture config, go LOAD; data_in_tready=0.
REQ-008 Repeat count R SHALL be 6 for factor 2, 9 for factor 3, 18 for any other value (3 data REs per DMRS tone).
REQ-009 Symbol count S SHALL equal config[4:3]; value 0 treated as 1.
REQ-010 LOAD: data_in_tready=1; on handshake register tdata/tlast into holding register, clear repeat counter, go EXPAND.
REQ-011 EXPAND: data_out_tvalid=1, data_out_tdata = held estimate unchanged bit-for-bit; repeat counter increments only on data_out_tvalid && data_out_tready.
REQ-012 data_out_tlast SHALL be 1 only on beat R-1 of an estimate captured with tlast=1.
REQ-013 data_out_tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-014 At beat R-1 handshake: if held tlast=1 and symbol counter reaches S, go IDLE; if held tlast=1 otherwise, increment symbol counter, go LOAD; if held tlast=0, refill directly.
REQ-015 Refill: data_in_tready SHALL also be 1 in EXPAND when counter=R-1, data_out_tready=1 and held tlast=0; on input handshake in that cycle, load new estimate and stay EXPAND with zero bubble; without input, go LOAD.
REQ-016 Latency: input handshake at cycle N -> first output beat valid at cycle N+1.
REQ-017 Config input SHALL be ignored outside IDLE; data_in SHALL not be accepted in IDLE.
REQ-018 Outputs SHALL be driven from registers except data_in_tready/config_in_tready (state decodes).

Reset
REQ-019 rstn low SHALL asynchronously force state IDLE, counters 0, data_out_tdata 0, data_out_tvalid 0, data_out_tlast 0, data_in_tready 0.
REQ-020 config_in_tready SHALL be 0 while rstn low and 1 the first cycle after release.
REQ-021 Reset mid-EXPAND SHALL drop the held estimate with no further output beat.

Configuration
REQ-022 Macro WN_PDCCHRX_CHEST_EXPAND_REIDX_EN SHALL add output port data_out_tuser (11b), the data-RE index within the current symbol, 0 on first beat, +1 per output handshake, cleared after tlast beat and on reset.
REQ-023 Without WN_PDCCHRX_CHEST_EXPAND_REIDX_EN the port and index counter SHALL not exist; all other behaviour identical.

Verification
REQ-024 Factor 2, S=1, 2 estimates (second tlast), tready=1 -> 12 beats, 6 each value, tlast on beat 12, then config_in_tready=1.
REQ-025 Factor 3, continuous input, tready=1 -> no gaps between estimates, 9 beats per value, data_in_tready pulses once per 9 cycles.
REQ-026 Factor 6, tready toggling 1010 -> 18 accepted beats per value, tdata stable while stalled, none lost or duplicated.
REQ-027 Config 0b10_010 (S=2) -> two tlast outputs, IDLE only after second; config pulse in EXPAND ignored.
REQ-028 rstn asserted at beat 4 of EXPAND -> tvalid 0 immediately; after release a new config plus 1 estimate gives correct R beats; with macro, tuser 0..R-1.
